// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: memory-controller state encoding and bus defaults.
package lc3_pkg;

  typedef enum logic [1:0] {
    MC_IDLE,
    MC_WAIT,
    MC_RESP
  } mem_state_t;

  localparam int          MEM_TIMEOUT_DEFAULT = 15;
  localparam logic [15:0] MEM_ERR_DATA        = 16'h0000;

endpackage : lc3_pkg

// File: rtl/lc3_timeout_counter.sv
// Bus-cycle watchdog: counts enabled cycles and flags the last allowed one.
module lc3_timeout_counter #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int                CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign expired = enable && (count_q == LAST);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : lc3_timeout_counter

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory-bus controller: one request in flight, variable-latency ack,
// bounded by a timeout that returns an error response instead of hanging.
module lc3_mem_ctrl
  import lc3_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  mem_state_t        state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              expired;

  // Counter runs only on ack-less WAIT cycles, so an ack on the final count wins.
  lc3_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q == MC_IDLE),
    .enable  ((state_q == MC_WAIT) && !mem_ack),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      MC_IDLE: begin
        if (req_valid) begin
          state_d = MC_WAIT;
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
        end
      end
      MC_WAIT: begin
        if (mem_ack) begin
          state_d = MC_RESP;
          rdata_d = we_q ? '0 : mem_rdata;
          err_d   = 1'b0;
        end else if (expired) begin
          state_d = MC_RESP;
          rdata_d = DATA_W'(MEM_ERR_DATA);
          err_d   = 1'b1;
        end
      end
      MC_RESP: state_d = MC_IDLE;
      default: state_d = MC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MC_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == MC_IDLE);
  assign busy      = (state_q != MC_IDLE);
  assign mem_en    = (state_q == MC_WAIT);
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rsp_valid = (state_q == MC_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule : lc3_mem_ctrl

// File: tb/tb_lc3_mem_ctrl.sv
// Self-checking bench for lc3_mem_ctrl: directed table, random transactions
// against a transaction-level model, plus reset and back-to-back sequences.
module tb_lc3_mem_ctrl;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err, busy;
  logic [15:0] rsp_rdata;
  logic        mem_en, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int rsp_seen = 0;
  int rsp_exp  = 0;

  always #5 clk = ~clk;

  lc3_mem_ctrl #(
    .ADDR_W  (16),
    .DATA_W  (16),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always @(negedge clk) if (rsp_valid === 1'b1) rsp_seen++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Transaction-level model: ack on mem_en cycle k (1-based, 0 = never) succeeds
  // only if k fits inside the TIMEOUT window; otherwise the bus times out.
  task automatic model(input logic we, input logic [15:0] rd, input int ack_cycle,
                       output logic err, output logic [15:0] rdata, output int cycles);
    if (ack_cycle >= 1 && ack_cycle <= TIMEOUT) begin
      err    = 1'b0;
      rdata  = we ? 16'h0000 : rd;
      cycles = ack_cycle;
    end else begin
      err    = 1'b1;
      rdata  = 16'h0000;
      cycles = TIMEOUT;
    end
  endtask

  // Runs one request from IDLE through RESP and back to IDLE.
  task automatic run_txn(input string name, input logic we, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [15:0] rd, input int ack_cycle,
                         input logic exp_err, input logic [15:0] exp_rdata, input int exp_cycles);
    int en_cycles = 0;
    bit done = 0;
    @(negedge clk);
    check_bit({name, "_ready"}, req_ready, 1'b1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = 16'($urandom);
    req_wdata = 16'($urandom);
    for (int c = 1; c <= TIMEOUT + 5 && !done; c++) begin
      if (mem_en) begin
        en_cycles++;
        check_bit({name, "_mem_we"}, mem_we, we);
        check_word({name, "_mem_addr"}, mem_addr, addr);
        check_word({name, "_mem_wdata"}, mem_wdata, wdata);
        mem_ack   = (c == ack_cycle);
        mem_rdata = (c == ack_cycle) ? rd : 16'($urandom);
        @(negedge clk);
      end else begin
        done = 1;
      end
    end
    mem_ack = 1'b0;
    check_bit({name, "_en_drop"}, done, 1'b1);
    check_int({name, "_en_cycles"}, en_cycles, exp_cycles);
    check_bit({name, "_rsp_valid"}, rsp_valid, 1'b1);
    check_word({name, "_rsp_rdata"}, rsp_rdata, exp_rdata);
    check_bit({name, "_rsp_err"}, rsp_err, exp_err);
    check_bit({name, "_busy_resp"}, busy, 1'b1);
    rsp_exp++;
    @(negedge clk);
    check_bit({name, "_rsp_pulse"}, rsp_valid, 1'b0);
    check_bit({name, "_ready_after"}, req_ready, 1'b1);
    check_word({name, "_rdata_hold"}, rsp_rdata, exp_rdata);
    check_bit({name, "_err_hold"}, rsp_err, exp_err);
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rd;
    int          ack_cycle;
    logic        exp_err;
    logic [15:0] exp_rdata;
    int          exp_cycles;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic        m_err;
    logic [15:0] m_rdata;
    int          m_cycles;
    logic        r_we;
    logic [15:0] r_rd;
    int          r_ack;

    vecs[0] = '{1'b0, 16'h3000, 16'h0000, 16'h1234, 1,  1'b0, 16'h1234, 1};
    vecs[1] = '{1'b1, 16'h4001, 16'hBEEF, 16'h9999, 5,  1'b0, 16'h0000, 5};
    vecs[2] = '{1'b0, 16'h5000, 16'h0000, 16'h4444, 0,  1'b1, 16'h0000, 15};
    vecs[3] = '{1'b0, 16'h5002, 16'h0000, 16'hABCD, 15, 1'b0, 16'hABCD, 15};
    vecs[4] = '{1'b1, 16'hFFFF, 16'h0001, 16'h2222, 0,  1'b1, 16'h0000, 15};
    vecs[5] = '{1'b0, 16'h0000, 16'h0000, 16'hFFFF, 14, 1'b0, 16'hFFFF, 14};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    check_bit("rst_req_ready", req_ready, 1'b1);
    check_bit("rst_rsp_valid", rsp_valid, 1'b0);
    check_bit("rst_rsp_err", rsp_err, 1'b0);
    check_word("rst_rsp_rdata", rsp_rdata, 16'h0000);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_mem_en", mem_en, 1'b0);
    check_bit("rst_mem_we", mem_we, 1'b0);
    check_word("rst_mem_addr", mem_addr, 16'h0000);
    check_word("rst_mem_wdata", mem_wdata, 16'h0000);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rd,
              vecs[i].ack_cycle, vecs[i].exp_err, vecs[i].exp_rdata, vecs[i].exp_cycles);
    end

    for (int i = 0; i < 30; i++) begin
      r_we  = 1'($urandom);
      r_rd  = 16'($urandom);
      r_ack = $urandom_range(0, TIMEOUT + 3);
      model(r_we, r_rd, r_ack, m_err, m_rdata, m_cycles);
      run_txn($sformatf("rnd%0d", i), r_we, 16'($urandom), 16'($urandom), r_rd, r_ack,
              m_err, m_rdata, m_cycles);
    end

    // Reset during WAIT cycle 3 drops the request; a late ack is ignored.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h6000;
    @(negedge clk);
    req_valid = 1'b0;
    check_bit("rstw_en_c1", mem_en, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check_bit("rstw_en_c3", mem_en, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_bit("rstw_mem_en", mem_en, 1'b0);
    check_bit("rstw_busy", busy, 1'b0);
    check_bit("rstw_rsp_valid", rsp_valid, 1'b0);
    mem_ack = 1'b1; mem_rdata = 16'h7E7E;
    @(negedge clk);
    mem_ack = 1'b0;
    check_bit("rstw_late_ack_rsp", rsp_valid, 1'b0);
    check_bit("rstw_late_ack_busy", busy, 1'b0);
    check_bit("rstw_late_ack_en", mem_en, 1'b0);

    // Stray ack in IDLE, then req_valid held across two back-to-back requests.
    mem_ack = 1'b1; mem_rdata = 16'h5555;
    @(negedge clk);
    mem_ack = 1'b0;
    check_bit("b2b_stray_rsp", rsp_valid, 1'b0);
    check_bit("b2b_stray_busy", busy, 1'b0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0100; req_wdata = 16'h0000;
    @(negedge clk);
    check_bit("b2b_a_en", mem_en, 1'b1);
    check_word("b2b_a_addr", mem_addr, 16'h0100);
    check_bit("b2b_a_ready", req_ready, 1'b0);
    req_we = 1'b1; req_addr = 16'h0200; req_wdata = 16'hCAFE;
    mem_ack = 1'b1; mem_rdata = 16'hAAAA;
    @(negedge clk);
    check_bit("b2b_a_rsp", rsp_valid, 1'b1);
    check_word("b2b_a_rdata", rsp_rdata, 16'hAAAA);
    check_bit("b2b_a_resp_ready", req_ready, 1'b0);
    check_bit("b2b_a_resp_en", mem_en, 1'b0);
    rsp_exp++;
    mem_ack = 1'b1; mem_rdata = 16'h7777;
    @(negedge clk);
    mem_ack = 1'b0;
    check_bit("b2b_idle_ready", req_ready, 1'b1);
    check_bit("b2b_idle_rsp", rsp_valid, 1'b0);
    check_bit("b2b_idle_en", mem_en, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    check_bit("b2b_b_en", mem_en, 1'b1);
    check_bit("b2b_b_we", mem_we, 1'b1);
    check_word("b2b_b_addr", mem_addr, 16'h0200);
    check_word("b2b_b_wdata", mem_wdata, 16'hCAFE);
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    @(negedge clk);
    mem_ack = 1'b0;
    check_bit("b2b_b_rsp", rsp_valid, 1'b1);
    check_word("b2b_b_rdata", rsp_rdata, 16'h0000);
    check_bit("b2b_b_err", rsp_err, 1'b0);
    rsp_exp++;
    @(negedge clk);
    check_bit("b2b_end_ready", req_ready, 1'b1);
    check_bit("b2b_end_rsp", rsp_valid, 1'b0);

    @(negedge clk);
    check_int("rsp_pulse_total", rsp_seen, rsp_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_lc3_mem_ctrl
